// File: rtl/cmd_exec_resp.sv
// Command-execution responder: accepts one vld_i command, executes it on two W-bit operands, answers with done/rdy.
// Build option FAST_MULT_EN: MULT becomes a single-cycle combinational multiply instead of ITER shift-add steps.
//
// state    | meaning
// S_IDLE   | waiting for vld_i; the cycle showing rdy_o is still closed to new commands
// S_ITER   | one MULT/DIV/REM bit step per cycle, cnt counts down to terminal count 1
// S_EXEC   | result/error selection into res_r
// S_RESP   | loads the registered outputs, rdy_o/done_o show in the following cycle
// S_HALTED | after HLT: only RST executes, everything else is answered with err_o
module cmd_exec_resp #(
    parameter int W    = 64,
    parameter int ITER = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_i,
    input  logic [2:0]   cmd_i,
    input  logic [W-1:0] opd1_i,
    input  logic [W-1:0] opd2_i,
    output logic         rdy_o,
    output logic         done_o,
    output logic [2:0]   done_cmd_o,
    output logic [W-1:0] result_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         ovr_o
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_RESP, S_HALTED} state_t;
    typedef enum logic [2:0] {
        CMD_RST, CMD_INIT, CMD_ADD, CMD_SUB, CMD_MULT, CMD_DIV, CMD_REM, CMD_HLT
    } cmd_t;

    state_t         state;
    cmd_t           cmd_r, cmd_in;
    logic [W-1:0]   a_r, b_r, acc, res_r, exec_res;
    logic [CW-1:0]  cnt;
    logic [W:0]     div_trial;
    logic           err_r, exec_err, halt_rej, halt_nxt;
    logic           accept, viol, multi;

    always_comb begin
        cmd_in = cmd_t'(cmd_i);
        accept = vld_i && (state == S_IDLE || state == S_HALTED) && !rdy_o;
        viol   = vld_i && !accept;
`ifdef FAST_MULT_EN
        multi  = (cmd_in == CMD_DIV || cmd_in == CMD_REM) && (opd2_i != '0);
`else
        multi  = ((cmd_in == CMD_DIV || cmd_in == CMD_REM) && (opd2_i != '0))
                 || (cmd_in == CMD_MULT);
`endif
        // acc holds the partial remainder, a_r shifts the dividend out and the quotient in
        div_trial = {acc, a_r[W-1]} - {1'b0, b_r};
    end

    always_comb begin
        exec_res = '0;
        exec_err = 1'b0;
        if (halt_rej) begin
            exec_res = result_o;
            exec_err = 1'b1;
        end else begin
            case (cmd_r)
                CMD_INIT: exec_res = a_r;
                CMD_ADD:  exec_res = a_r + b_r;
                CMD_SUB:  exec_res = a_r - b_r;
`ifdef FAST_MULT_EN
                CMD_MULT: exec_res = a_r * b_r;
`else
                CMD_MULT: exec_res = acc;
`endif
                CMD_DIV: begin
                    exec_res = (b_r == '0) ? '1 : a_r;
                    exec_err = (b_r == '0);
                end
                CMD_REM: begin
                    exec_res = (b_r == '0) ? a_r : acc;
                    exec_err = (b_r == '0);
                end
                default:  exec_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_r      <= CMD_RST;
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            cnt        <= '0;
            res_r      <= '0;
            err_r      <= 1'b0;
            halt_rej   <= 1'b0;
            halt_nxt   <= 1'b0;
            rdy_o      <= 1'b0;
            done_o     <= 1'b0;
            done_cmd_o <= '0;
            result_o   <= '0;
            err_o      <= 1'b0;
            busy_o     <= 1'b0;
            ovr_o      <= 1'b0;
        end else begin
            rdy_o  <= 1'b0;
            done_o <= 1'b0;
            if (viol) ovr_o <= 1'b1;
            case (state)
                S_IDLE, S_HALTED: begin
                    busy_o <= 1'b0;
                    if (accept) begin
                        busy_o   <= 1'b1;
                        cmd_r    <= cmd_in;
                        a_r      <= opd1_i;
                        b_r      <= opd2_i;
                        acc      <= '0;
                        cnt      <= CW'(ITER);
                        halt_rej <= (state == S_HALTED) && (cmd_in != CMD_RST);
                        state    <= (state == S_IDLE && multi) ? S_ITER : S_EXEC;
                    end
                end
                S_ITER: begin
                    if (cmd_r == CMD_MULT) begin
                        if (b_r[0]) acc <= acc + a_r;
                        a_r <= a_r << 1;
                        b_r <= b_r >> 1;
                    end else if (!div_trial[W]) begin
                        acc <= div_trial[W-1:0];
                        a_r <= {a_r[W-2:0], 1'b1};
                    end else begin
                        acc <= {acc[W-2:0], a_r[W-1]};
                        a_r <= {a_r[W-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_EXEC;
                end
                S_EXEC: begin
                    res_r    <= exec_res;
                    err_r    <= exec_err;
                    halt_nxt <= halt_rej || (cmd_r == CMD_HLT);
                    if (!halt_rej && cmd_r == CMD_RST) ovr_o <= viol;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    rdy_o      <= 1'b1;
                    done_o     <= 1'b1;
                    done_cmd_o <= cmd_r;
                    result_o   <= res_r;
                    err_o      <= err_r;
                    state      <= halt_nxt ? S_HALTED : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_exec_resp.sv
// Scoreboard bench for cmd_exec_resp: stimulus pushes model-predicted responses, a monitor pops them on done_o.
module tb_cmd_exec_resp;
    localparam int W    = 64;
    localparam int ITER = W;

    logic         clk = 1'b0, rst = 1'b1, vld_i = 1'b0;
    logic [2:0]   cmd_i = '0;
    logic [W-1:0] opd1_i = '0, opd2_i = '0;
    logic         rdy_o, done_o, err_o, busy_o, ovr_o;
    logic [2:0]   done_cmd_o;
    logic [W-1:0] result_o;

    always #5 clk = ~clk;

    cmd_exec_resp #(.W(W), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .vld_i(vld_i), .cmd_i(cmd_i), .opd1_i(opd1_i), .opd2_i(opd2_i),
        .rdy_o(rdy_o), .done_o(done_o), .done_cmd_o(done_cmd_o), .result_o(result_o),
        .err_o(err_o), .busy_o(busy_o), .ovr_o(ovr_o)
    );

    typedef struct {
        logic [2:0]   cmd;
        logic [W-1:0] res;
        logic         err;
        int           due;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           checks = 0, failures = 0, cyc = 0;
    logic         prev_done = 1'b0;
    logic         m_halted = 1'b0, m_ovr = 1'b0;
    logic [W-1:0] m_last = '0;

`ifdef FAST_MULT_EN
    localparam logic [2:0] LONG_CMD = 3'd5;
`else
    localparam logic [2:0] LONG_CMD = 3'd4;
`endif

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: plain arithmetic plus a halted flag and the last reported result.
    function automatic void model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e, output int lat);
        e   = 1'b0;
        lat = 2;
        r   = '0;
        if (m_halted && c != 3'd0) begin
            r = m_last;
            e = 1'b1;
        end else begin
            case (c)
                3'd0: begin r = '0; m_ovr = 1'b0; m_halted = 1'b0; end
                3'd1: r = a;
                3'd2: r = a + b;
                3'd3: r = a - b;
                3'd4: begin
                    r = a * b;
`ifndef FAST_MULT_EN
                    lat = ITER + 2;
`endif
                end
                3'd5: if (b == '0) begin r = '1; e = 1'b1; end
                      else begin r = a / b; lat = ITER + 2; end
                3'd6: if (b == '0) begin r = a; e = 1'b1; end
                      else begin r = a % b; lat = ITER + 2; end
                default: begin r = '0; m_halted = 1'b1; end
            endcase
        end
        m_last = r;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (done_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done_o=1 cmd=%0d, expected no completion (cycle %0d)",
                         done_cmd_o, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("done_cmd", W'(done_cmd_o), W'(mon_e.cmd));
                chk("result", result_o, mon_e.res);
                chk("err", W'(err_o), W'(mon_e.err));
                chk("latency", W'(cyc), W'(mon_e.due));
                chk("rdy_with_done", W'(rdy_o), W'(1));
                chk("busy_in_resp", W'(busy_o), W'(1));
            end
            chk("done_single_cycle", W'(prev_done), W'(0));
        end
        prev_done = done_o;
    end

    task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W-1:0] r;
        logic         er;
        int           lat;
        @(negedge clk);
        chk("busy_before_issue", W'(busy_o), W'(0));
        vld_i  = 1'b1;
        cmd_i  = c;
        opd1_i = a;
        opd2_i = b;
        model(c, a, b, r, er, lat);
        e.cmd = c;
        e.res = r;
        e.err = er;
        e.due = cyc + 1 + lat;
        q.push_back(e);
        @(negedge clk);
        vld_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL completion_timeout: got no done_o after %0d cycles, expected %0d pending", n, q.size());
            q.delete();
        end
    endtask

    task automatic pulse(input logic [2:0] c);
        vld_i = 1'b1;
        cmd_i = c;
        @(negedge clk);
        vld_i = 1'b0;
        m_ovr = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rc;

        repeat (5) @(negedge clk);
        chk("rst_rdy", W'(rdy_o), W'(0));
        chk("rst_done", W'(done_o), W'(0));
        chk("rst_done_cmd", W'(done_cmd_o), W'(0));
        chk("rst_result", result_o, '0);
        chk("rst_err", W'(err_o), W'(0));
        chk("rst_busy", W'(busy_o), W'(0));
        chk("rst_ovr", W'(ovr_o), W'(0));
        rst = 1'b0;

        issue(3'd2, 64'd5, 64'd7);
        wait_done(ITER + 20);
        chk("add_5_7", result_o, 64'd12);
        issue(3'd3, 64'd3, 64'd5);
        wait_done(ITER + 20);
        chk("sub_wrap", result_o, 64'hFFFF_FFFF_FFFF_FFFE);

        issue(3'd5, 64'd100, 64'd7);
        repeat (30) @(negedge clk);
        chk("busy_mid_div", W'(busy_o), W'(1));
        wait_done(ITER + 20);
        chk("div_100_7", result_o, 64'd14);
        issue(3'd6, 64'd100, 64'd7);
        wait_done(ITER + 20);
        chk("rem_100_7", result_o, 64'd2);

        issue(3'd5, 64'd9, 64'd0);
        wait_done(ITER + 20);
        issue(3'd6, 64'd9, 64'd0);
        wait_done(ITER + 20);
        chk("rem_by_zero", result_o, 64'd9);

        issue(LONG_CMD, 64'd3, 64'd4);
        repeat (9) @(negedge clk);
        pulse(3'd2);
        wait_done(ITER + 20);
        chk("ovr_after_busy_vld", W'(ovr_o), W'(m_ovr));
        repeat (3) @(negedge clk);
        chk("ovr_sticky", W'(ovr_o), W'(1));
        issue(3'd0, 64'd0, 64'd0);
        wait_done(ITER + 20);
        chk("ovr_cleared_by_rst_cmd", W'(ovr_o), W'(0));

        issue(3'd2, 64'd1, 64'd2);
        wait_done(ITER + 20);
        pulse(3'd2);
        chk("ovr_vld_in_resp", W'(ovr_o), W'(1));
        repeat (4) @(negedge clk);
        issue(3'd0, 64'd0, 64'd0);
        wait_done(ITER + 20);

        issue(3'd7, 64'd0, 64'd0);
        wait_done(ITER + 20);
        issue(3'd2, 64'd1, 64'd1);
        wait_done(ITER + 20);
        issue(3'd0, 64'd0, 64'd0);
        wait_done(ITER + 20);
        issue(3'd2, 64'd1, 64'd1);
        wait_done(ITER + 20);
        chk("add_after_unhalt", result_o, 64'd2);

        @(negedge clk);
        vld_i  = 1'b1;
        cmd_i  = LONG_CMD;
        opd1_i = 64'd1000;
        opd2_i = 64'd3;
        @(negedge clk);
        vld_i = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("abort_rdy", W'(rdy_o), W'(0));
        chk("abort_done", W'(done_o), W'(0));
        chk("abort_done_cmd", W'(done_cmd_o), W'(0));
        chk("abort_result", result_o, '0);
        chk("abort_err", W'(err_o), W'(0));
        chk("abort_busy", W'(busy_o), W'(0));
        chk("abort_ovr", W'(ovr_o), W'(0));
        @(negedge clk);
        rst      = 1'b0;
        m_halted = 1'b0;
        m_ovr    = 1'b0;
        m_last   = '0;
        issue(3'd2, 64'd2, 64'd2);
        wait_done(ITER + 20);
        chk("add_after_abort", result_o, 64'd4);

        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                ra = W'($urandom_range(0, 1000));
                rb = W'($urandom_range(0, 40));
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            end
            if ($urandom_range(0, 7) == 0) rb = '0;
            issue(rc, ra, rb);
            wait_done(ITER + 20);
            chk("ovr_random", W'(ovr_o), W'(m_ovr));
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_exec_resp.md
# cmd_exec_resp

Command-execution responder: the receiving end of the vld/rdy command interface that the stimulus generator drives. It accepts one command per handshake (RST, INIT, ADD, SUB, MULT, DIV, REM, HLT), executes it on two 64-bit operands, then reports completion with done/done_cmd plus a ready pulse. It sits behind the command initiator as the device under test for the command-protocol assertions.

## Interface
- W, 64, operand/result width
- ITER, W, iterations for multi-cycle MULT/DIV/REM (one bit per cycle)

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  reset, synchronous, active-high
- vld_i  input  1  command valid, single-cycle pulse
- cmd_i  input  3  command: RST=0, INIT=1, ADD=2, SUB=3, MULT=4, DIV=5, REM=6, HLT=7
- opd1_i  input  W  operand 1
- opd2_i  input  W  operand 2
- rdy_o  output  1  ready pulse; initiator may issue the next vld after it
- done_o  output  1  completion pulse, coincident with rdy_o
- done_cmd_o  output  3  command just completed, valid with done_o
- result_o  output  W  result, held until the next done_o
- err_o  output  1  per-command error, valid with done_o
- busy_o  output  1  command in flight
- ovr_o  output  1  sticky protocol violation (vld_i while busy or before rdy_o)

## Operation
- States: IDLE, EXEC, ITER, RESP, HALTED.
- IDLE: vld_i=1 at an edge latches cmd_i/opd1_i/opd2_i. Next state is EXEC for single-cycle commands and ITER for multi-cycle commands.
- Single-cycle commands:
  - ADD: result = opd1+opd2, mod 2^W.
  - SUB: result = opd1−opd2, mod 2^W, two's complement wrap.
  - INIT: result = opd1.
  - RST: result = 0, clears ovr_o, returns to IDLE.
  - HLT: result = 0, then next state is HALTED.
- Multi-cycle commands, unsigned:
  - MULT: shift-add, low W bits of the product.
  - DIV: restoring division, quotient.
  - REM: restoring division, remainder.
- Divide by zero (DIV/REM with opd2=0): takes the single-cycle path. DIV returns all-ones, REM returns opd1, err_o=1.
- RESP: one cycle with rdy_o=done_o=1. done_cmd_o = latched cmd, result_o updated. Then IDLE, or HALTED after HLT.
- HALTED: responds to every vld_i with a single-cycle RESP.
  - RST: normal execution, then IDLE.
  - Any other command: result_o unchanged, err_o=1, state stays HALTED.
- vld_i in EXEC/ITER/RESP: ignored, ovr_o set to 1. ovr_o clears only on rst or an executed RST command.

## Timing
- Reset values: rdy_o=0, done_o=0, done_cmd_o=0, result_o=0, err_o=0, busy_o=0, ovr_o=0. State = IDLE.
- vld_i sampled at edge k.
- Single-cycle commands: rdy_o/done_o high for exactly the cycle after edge k+2.
- MULT/DIV/REM: rdy_o/done_o high for the cycle after edge k+ITER+2.
- busy_o high from edge k+1 through the RESP cycle inclusive.
- rdy_o/done_o are never high for more than one consecutive cycle.
- vld_i coincident with the RESP cycle: counts as a violation and is dropped.
- vld_i is accepted from the first IDLE cycle after RESP.
- rst mid-operation: aborts EXEC/ITER/RESP and HALTED. No done_o is produced. All outputs return to reset values at that edge.

## Configuration
- FAST_MULT_EN
  - Defined: MULT uses a combinational W×W multiply (low W bits) and takes the single-cycle path.
  - Undefined: MULT is iterative as above.
- DIV/REM are unaffected either way.

## Test plan
- rst 5 cycles, then ADD 5,7: done_o at k+2, result_o=12, done_cmd_o=2, err_o=0. Then SUB 3,5: result_o=0xFFFF_FFFF_FFFF_FFFE.
- DIV 100,7: done_o at k+66, result_o=14. Then REM 100,7: result_o=2. busy_o high throughout.
- DIV 9,0: done_o at k+2, result_o=all-ones, err_o=1. Then REM 9,0: result_o=9, err_o=1.
- MULT 3,4, then a vld_i pulse 10 cycles later: ovr_o=1 and stays 1. A single done_o with result_o=12. The next RST clears ovr_o.
- HLT, then ADD 1,1: done_o with err_o=1, result_o=0, still HALTED. Then RST: done_cmd_o=0, back to IDLE. ADD 1,1 then gives 2.
- Start MULT, assert rst at iteration 20: no done_o, all outputs 0. A following ADD 2,2 completes normally with result_o=4.
